// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared constants and types for the 8x32 register file.
//   DATA_W  : word width in bits
//   REG_CNT : number of registers (power of two)
//   ADDR_W  : address width, log2(REG_CNT)
//   data_t  : one data word
//   addr_t  : one register address
// -----------------------------------------------------------------------------
package reg_file_pkg;

   localparam int DATA_W  = 32;
   localparam int REG_CNT = 8;
   localparam int ADDR_W  = $clog2(REG_CNT);

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage : reg_file_pkg

// File: rtl/register_file_8x32_dff_r_en_word.sv
// -----------------------------------------------------------------------------
// dff_r_en_word
// Word-wide enable register made of W replicated enable flip-flops, each with
// an asynchronous active-high reset to 0.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   en_i  : load enable; the word holds while low
//   d_i   : data to load
//   q_o   : registered word
// -----------------------------------------------------------------------------
module dff_r_en_word #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] bit_q;

   for (genvar b = 0; b < W; b++) begin : g_bit
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            bit_q[b] <= 1'b0;
         end else if (en_i) begin
            bit_q[b] <= d_i[b];
         end
      end
   end

   assign q_o = bit_q;

endmodule : dff_r_en_word

// File: rtl/register_file_8x32.sv
// -----------------------------------------------------------------------------
// register_file_8x32
// Eight 32-bit registers, one write port, two independent registered read
// ports (one-cycle read latency). Storage and read output registers are all
// dff_r_en_word instances.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset; clears storage and outputs
//   we         : write enable
//   wr_addr    : write address
//   wr_data    : write data
//   rd_addr_a  : read port A address
//   rd_addr_b  : read port B address
//   rd_data_a  : read port A data, registered
//   rd_data_b  : read port B data, registered
// Build option:
//   REG_FILE_BYPASS_EN : when defined, a read of the register being written in
//   the same cycle returns the new wr_data (write-to-read forwarding). When
//   undefined, such a read returns the pre-write value.
// -----------------------------------------------------------------------------
module register_file_8x32
   import reg_file_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b
);

   logic [REG_CNT-1:0] wr_en;
   data_t              reg_q [REG_CNT];
   data_t              rd_a_d;
   data_t              rd_b_d;
   data_t              rd_a_q;
   data_t              rd_b_q;

   // One-hot write decoder; all-zero when we is low.
   always_comb begin
      wr_en = '0;
      if (we) begin
         wr_en[wr_addr] = 1'b1;
      end
   end

   for (genvar i = 0; i < REG_CNT; i++) begin : g_reg
      dff_r_en_word #(.W(DATA_W)) u_reg (
         .clk  (clk),
         .rst  (reset),
         .en_i (wr_en[i]),
         .d_i  (wr_data),
         .q_o  (reg_q[i])
      );
   end

   // Read muxes. With forwarding, a matching in-flight write overrides the
   // stored word so the output register captures the new value at this edge.
   always_comb begin
      rd_a_d = reg_q[rd_addr_a];
      rd_b_d = reg_q[rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
      if (we && (wr_addr == rd_addr_a)) begin
         rd_a_d = wr_data;
      end
      if (we && (wr_addr == rd_addr_b)) begin
         rd_b_d = wr_data;
      end
`endif
   end

   // Output registers load every cycle.
   dff_r_en_word #(.W(DATA_W)) u_rd_a (
      .clk  (clk),
      .rst  (reset),
      .en_i (1'b1),
      .d_i  (rd_a_d),
      .q_o  (rd_a_q)
   );

   dff_r_en_word #(.W(DATA_W)) u_rd_b (
      .clk  (clk),
      .rst  (reset),
      .en_i (1'b1),
      .d_i  (rd_b_d),
      .q_o  (rd_b_q)
   );

   assign rd_data_a = rd_a_q;
   assign rd_data_b = rd_b_q;

endmodule : register_file_8x32

// File: tb/tb_register_file_8x32.sv
// -----------------------------------------------------------------------------
// tb_register_file_8x32
// Self-checking bench for register_file_8x32. A plain array holds the
// architectural register contents; each cycle's expected read data is derived
// from it (plus forwarding when REG_FILE_BYPASS_EN is defined) and queued, then
// popped and compared half a cycle after the active edge.
// -----------------------------------------------------------------------------
module tb_register_file_8x32;

   logic        clk;
   logic        reset;
   logic        we;
   logic [2:0]  wr_addr;
   logic [31:0] wr_data;
   logic [2:0]  rd_addr_a;
   logic [2:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl [8];
   logic [31:0] exp_q [$];

   register_file_8x32 dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic sb_pop(input string tag, input logic [31:0] got);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         e = 32'hxxxx_xxxx;
         check_val({tag, "_noexp"}, got, e);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, got, e);
      end
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < 8; i++) mdl[i] = '0;
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge. Applies inputs, queues expectations,
   // crosses one rising edge and checks at the following falling edge.
   task automatic drive_cycle(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                              input logic [2:0] ra, input logic [2:0] rb, input string tag);
      logic [31:0] ea;
      logic [31:0] eb;
      we        = w;
      wr_addr   = wa;
      wr_data   = wd;
      rd_addr_a = ra;
      rd_addr_b = rb;
      ea = mdl[ra];
      eb = mdl[rb];
`ifdef REG_FILE_BYPASS_EN
      if (w && (wa == ra)) ea = wd;
      if (w && (wa == rb)) eb = wd;
`endif
      exp_q.push_back(ea);
      exp_q.push_back(eb);
      @(posedge clk);
      if (w) mdl[wa] = wd;
      @(negedge clk);
      sb_pop({tag, "_a"}, rd_data_a);
      sb_pop({tag, "_b"}, rd_data_b);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b0;
      we        = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      mdl_clear();

      // Power-up reset: outputs clear asynchronously.
      #2 reset = 1'b1;
      #1;
      check_val("por_a", rd_data_a, 32'h0);
      check_val("por_b", rd_data_b, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Write/read sweep.
      for (int i = 0; i < 8; i++)
         drive_cycle(1'b1, 3'(i), 32'hA5A5_0000 + 32'(i), 3'(7 - i), 3'(i), "sweep_wr");
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b0, 3'd0, 32'h0, 3'(i), 3'(7 - i), "sweep_rd");
         check_val("sweep_const", rd_data_a, 32'hA5A5_0000 + 32'(i));
      end

      // we=0 hold.
      drive_cycle(1'b1, 3'd3, 32'h1234_5678, 3'd0, 3'd1, "hold_wr");
      for (int i = 0; i < 3; i++)
         drive_cycle(1'b0, 3'd3, 32'hFFFF_FFFF, 3'd3, 3'd3, "hold");
      check_val("hold_const", rd_data_a, 32'h1234_5678);

      // Read-during-write.
      drive_cycle(1'b1, 3'd5, 32'h0000_0001, 3'd0, 3'd0, "rdw_init");
      drive_cycle(1'b1, 3'd5, 32'hDEAD_BEEF, 3'd5, 3'd4, "rdw");
`ifdef REG_FILE_BYPASS_EN
      check_val("rdw_now", rd_data_a, 32'hDEAD_BEEF);
`else
      check_val("rdw_now", rd_data_a, 32'h0000_0001);
`endif
      drive_cycle(1'b0, 3'd0, 32'h0, 3'd5, 3'd5, "rdw_next");
      check_val("rdw_next_const", rd_data_a, 32'hDEAD_BEEF);

      // Mid-cycle reset with nonzero contents.
      drive_cycle(1'b0, 3'd0, 32'h0, 3'd0, 3'd7, "pre_rst");
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("mid_rst_a", rd_data_a, 32'h0);
      check_val("mid_rst_b", rd_data_b, 32'h0);
      mdl_clear();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++)
         drive_cycle(1'b0, 3'd0, 32'h0, 3'(i), 3'(7 - i), "post_rst");

      // Reset coincident with a write: the write is discarded.
      drive_cycle(1'b1, 3'd2, 32'h1111_2222, 3'd0, 3'd0, "rdw2_pre");
      reset   = 1'b1;
      we      = 1'b1;
      wr_addr = 3'd2;
      wr_data = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      check_val("rst_wr_a", rd_data_a, 32'h0);
      mdl_clear();
      @(negedge clk);
      reset = 1'b0;
      we    = 1'b0;
      drive_cycle(1'b0, 3'd0, 32'h0, 3'd2, 3'd2, "rst_wr_rd");
      check_val("rst_wr_const", rd_data_a, 32'h0);

      // Dual port, same address.
      drive_cycle(1'b1, 3'd6, 32'h0F0F_0F0F, 3'd0, 3'd0, "dual_wr");
      drive_cycle(1'b0, 3'd0, 32'h0, 3'd6, 3'd6, "dual");
      check_val("dual_a_const", rd_data_a, 32'h0F0F_0F0F);
      check_val("dual_b_const", rd_data_b, 32'h0F0F_0F0F);

      // Back-to-back writes to one address: last wins.
      drive_cycle(1'b1, 3'd1, 32'h0000_00AA, 3'd1, 3'd2, "b2b_1");
      drive_cycle(1'b1, 3'd1, 32'h0000_00BB, 3'd1, 3'd2, "b2b_2");
      drive_cycle(1'b0, 3'd0, 32'h0, 3'd1, 3'd1, "b2b_rd");
      check_val("b2b_const", rd_data_a, 32'h0000_00BB);

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         drive_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rand");
      end

      // ---------------- report ----------------
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_register_file_8x32
